// File: rtl/shift_pkg.sv
// Shift-mode encodings shared by the pipelined shifter and the ALU decoder.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_mode_e;

endpackage

// File: rtl/shift_pipe_if.sv
// Valid/ready operand and result bus of the pipelined shifter.
interface shift_pipe_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [SHW-1:0]    in_amount;
    shift_mode_e       in_mode;
    logic              in_carry;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_carry;
    logic              out_zero;

    modport slave (
        input  in_valid, in_data, in_amount, in_mode, in_carry, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero
    );

    modport master (
        output in_valid, in_data, in_amount, in_mode, in_carry, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero
    );

endinterface

// File: rtl/shift_stage.sv
// One combinational shifter level: shifts by DIST when active, and replaces the
// travelling carry with the last bit shifted out.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic              active,
    input  shift_mode_e       mode,
    input  logic [WIDTH-1:0]  data,
    input  logic              sign,
    input  logic              carry,
    output logic [WIDTH-1:0]  res_data,
    output logic              res_carry
);

    always_comb begin
        // NOTE: outputs get defaults before the case so no path can infer a latch.
        res_data  = data;
        res_carry = carry;
        if (active) begin
            case (mode)
                SH_LSL: begin
                    res_data  = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                    res_carry = data[WIDTH-DIST];
                end
                SH_LSR: begin
                    res_data  = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
                    res_carry = data[DIST-1];
                end
                SH_ASR: begin
                    // sign is the operand's original MSB, carried alongside the data
                    res_data  = {{DIST{sign}}, data[WIDTH-1:DIST]};
                    res_carry = data[DIST-1];
                end
                SH_ROR: begin
                    res_data  = {data[DIST-1:0], data[WIDTH-1:DIST]};
                    res_carry = data[DIST-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one register level per shift-amount bit, LSB level
// first, with a single global stall driven by the output handshake.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    shift_pipe_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    typedef struct packed {
        logic              valid;
        logic [WIDTH-1:0]  data;
        logic [SHW-1:0]    amount;
        shift_mode_e       mode;
        logic              carry;
        logic              sign;
    } slice_t;

    slice_t [SHW-1:0] src;
    slice_t [SHW-1:0] nxt;
    slice_t [SHW-1:0] regs;
    logic             en;
    logic             unused_fields;

    assign en = !regs[SHW-1].valid || bus.out_ready;

    assign src[0] = '{valid:  bus.in_valid,
                      data:   bus.in_data,
                      amount: bus.in_amount,
                      mode:   bus.in_mode,
                      carry:  bus.in_carry,
                      sign:   bus.in_data[WIDTH-1]};

    for (genvar k = 0; k < SHW; k++) begin : g_level
        logic [WIDTH-1:0] st_data;
        logic             st_carry;

        if (k > 0) begin : g_link
            assign src[k] = regs[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .active    (src[k].amount[k]),
            .mode      (src[k].mode),
            .data      (src[k].data),
            .sign      (src[k].sign),
            .carry     (src[k].carry),
            .res_data  (st_data),
            .res_carry (st_carry)
        );

        assign nxt[k] = '{valid:  src[k].valid,
                          data:   st_data,
                          amount: src[k].amount,
                          mode:   src[k].mode,
                          carry:  st_carry,
                          sign:   src[k].sign};
    end

    // NOTE: the data fields are reset too, so out_zero reads 1 out of reset instead of X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every level samples pre-edge values.
            regs <= '0;
        end else if (en) begin
            regs <= nxt;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = regs[SHW-1].valid;
    assign bus.out_data  = regs[SHW-1].data;
    assign bus.out_carry = regs[SHW-1].carry;
    assign bus.out_zero  = (regs[SHW-1].data == '0);

    assign unused_fields = ^{regs[SHW-1].amount, regs[SHW-1].mode, regs[SHW-1].sign};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe at WIDTH=32 (five levels, five-cycle latency).
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int WIDTH = 32;
    localparam int LAT   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    shift_pipe_if #(.WIDTH(WIDTH)) bus ();

    shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Mode table: data, amount, mode, expected data, expected carry, expected zero
    logic [31:0] t_data [10] = '{32'h8000_0001, 32'h8000_0000, 32'h0000_00F1, 32'h8000_0000,
                                 32'h0000_0008, 32'hFFFF_FFFF, 32'h7000_0000, 32'h8000_0001,
                                 32'h1234_5678, 32'h1234_5678};
    logic [4:0]  t_amt  [10] = '{5'd1, 5'd4, 5'd4, 5'd1, 5'd4, 5'd31, 5'd31, 5'd31, 5'd8, 5'd12};
    shift_mode_e t_mode [10] = '{SH_LSR, SH_ASR, SH_ROR, SH_LSL, SH_ROR, SH_LSR, SH_ASR, SH_ASR,
                                 SH_ROR, SH_LSL};
    logic [31:0] t_exp  [10] = '{32'h4000_0000, 32'hF800_0000, 32'h1000_000F, 32'h0000_0000,
                                 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF,
                                 32'h7812_3456, 32'h4567_8000};
    logic        t_cy   [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        t_z    [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amount = '0;
        bus.in_mode   = SH_LSL;
        bus.in_carry  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    // Issues one op into an idle pipe and waits (bounded) for its result.
    task automatic run_op(input logic [31:0] d, input logic [4:0] n, input shift_mode_e m,
                          input logic cin, output logic [31:0] rd, output logic rc,
                          output logic rz, output logic rv, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amount = n;
        bus.in_mode   = m;
        bus.in_carry  = cin;
        bus.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rv = bus.out_valid;
        rd = bus.out_data;
        rc = bus.out_carry;
        rz = bus.out_zero;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=00000000", bus.out_data); end
        checks++;
        if (bus.out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry got=%b exp=0", bus.out_carry); end
        checks++;
        if (bus.out_zero !== 1'b1) begin errors++; $display("FAIL reset_out_zero got=%b exp=1", bus.out_zero); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_lsl_latency();
        logic [31:0] rd; logic rc, rz, rv; int lat;
        run_op(32'h0000_0001, 5'd31, SH_LSL, 1'b0, rd, rc, rz, rv, lat);
        checks++;
        if (rv !== 1'b1 || lat != LAT) begin errors++; $display("FAIL lsl31_latency got valid=%b lat=%0d exp valid=1 lat=%0d", rv, lat, LAT); end
        checks++;
        if (rd !== 32'h8000_0000) begin errors++; $display("FAIL lsl31_data got=%h exp=80000000", rd); end
        checks++;
        if (rc !== 1'b0) begin errors++; $display("FAIL lsl31_carry got=%b exp=0", rc); end
        checks++;
        if (rz !== 1'b0) begin errors++; $display("FAIL lsl31_zero got=%b exp=0", rz); end
    endtask

    task automatic test_modes();
        logic [31:0] rd; logic rc, rz, rv; int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(t_data[i], t_amt[i], t_mode[i], 1'b0, rd, rc, rz, rv, lat);
            checks++;
            if (rv !== 1'b1 || rd !== t_exp[i]) begin
                errors++; $display("FAIL mode_data[%0d] got valid=%b data=%h exp=%h", i, rv, rd, t_exp[i]);
            end
            checks++;
            if (rc !== t_cy[i]) begin errors++; $display("FAIL mode_carry[%0d] got=%b exp=%b", i, rc, t_cy[i]); end
            checks++;
            if (rz !== t_z[i]) begin errors++; $display("FAIL mode_zero[%0d] got=%b exp=%b", i, rz, t_z[i]); end
        end
    endtask

    task automatic test_amount_zero();
        logic [31:0] rd; logic rc, rz, rv; int lat;
        for (int c = 1; c >= 0; c--) begin
            run_op(32'hDEAD_BEEF, 5'd0, SH_ASR, 1'(c), rd, rc, rz, rv, lat);
            checks++;
            if (rv !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL amt0_data cin=%0d got valid=%b data=%h exp=deadbeef", c, rv, rd);
            end
            checks++;
            if (rc !== 1'(c)) begin errors++; $display("FAIL amt0_carry got=%b exp=%0d", rc, c); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [8] = '{32'h0000_00A5, 32'h0000_014A, 32'h0000_0294, 32'h0000_0528,
                                 32'h0000_0A50, 32'h0000_14A0, 32'h0000_2940, 32'h0000_5280};
        int          tx = 0;
        int          rx = 0;
        int          c  = 0;
        int          extra = 0;
        logic        held = 1'b0;
        logic [31:0] held_data = '0;
        while (rx < 8 && c < 60) begin
            @(negedge clk);
            bus.out_ready = !(c >= 7 && c <= 9);
            bus.in_valid  = (tx < 8);
            bus.in_data   = 32'h0000_00A5;
            bus.in_amount = 5'(tx);
            bus.in_mode   = SH_LSL;
            bus.in_carry  = 1'b0;
            #1;
            if (held) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held_data) begin
                    errors++; $display("FAIL stall_hold c=%0d got valid=%b data=%h exp valid=1 data=%h", c, bus.out_valid, bus.out_data, held_data);
                end
            end
            held      = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
            if (held) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d got=%b exp=0", c, bus.in_ready); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_data !== exp[rx]) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", rx, bus.out_data, exp[rx]); end
                rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
            c++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (rx != 8) begin errors++; $display("FAIL stream_count got=%0d exp=8", rx); end
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL stream_duplicates got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_flush();
        logic [31:0] rd; logic rc, rz, rv; int lat;
        int w = 0;
        int stale = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'h0000_0F00;
            bus.in_amount = 5'(i);
            bus.in_mode   = SH_LSR;
            bus.in_carry  = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_zero !== 1'b0) begin
            errors++; $display("FAIL flush_prefill got valid=%b zero=%b exp valid=1 zero=0", bus.out_valid, bus.out_zero);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.out_zero !== 1'b1) begin errors++; $display("FAIL flush_zero got=%b exp=1", bus.out_zero); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL flush_stale got=%0d exp=0", stale); end
        run_op(32'h0000_F800, 5'd12, SH_LSR, 1'b0, rd, rc, rz, rv, lat);
        checks++;
        if (rv !== 1'b1 || lat != LAT) begin errors++; $display("FAIL flush_new_latency got valid=%b lat=%0d exp valid=1 lat=%0d", rv, lat, LAT); end
        checks++;
        if (rd !== 32'h0000_000F) begin errors++; $display("FAIL flush_new_data got=%h exp=0000000f", rd); end
        checks++;
        if (rc !== 1'b1) begin errors++; $display("FAIL flush_new_carry got=%b exp=1", rc); end
    endtask

    initial begin
        test_reset();
        test_lsl_latency();
        test_modes();
        test_amount_zero();
        test_back_to_back();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
